// File: rtl/gf180mcu_evtsync_pkg.sv
// rtl/gf180mcu_evtsync_pkg.sv - shared states, default widths and saturating increment for the event synchroniser
package gf180mcu_evtsync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILT   = 2'd1,
        ASSERT = 2'd2,
        REARM  = 2'd3
    } evtsync_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DBNC_W      = 4;
    localparam int DEF_DBNC_CYC    = 8;
    localparam int DEF_CNT_W       = 8;

    // Holds at 2**w-1 instead of wrapping; w is expected to be below 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__evtsync_sync.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__evtsync_sync.sv - STAGES-deep synchroniser chain with synchronous active-low clear
module gf180mcu_fd_sc_mcu9t5v0__evtsync_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__evtsync_1.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__evtsync_1.sv - event capture: synchronise, debounce, REQ/ACK handshake, saturating count; GF180MCU_EVTSYNC_TIMING_EN adds a specify block
module gf180mcu_fd_sc_mcu9t5v0__evtsync_1
    import gf180mcu_evtsync_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DBNC_W      = DEF_DBNC_W,
    parameter int DBNC_CYC    = DEF_DBNC_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EVT,
    input  logic             ACK,
    output logic             REQ,
    output logic             BUSY,
    output logic [CNT_W-1:0] EVT_CNT,
    inout  wire              VDD,
    inout  wire              VSS
);

    evtsync_state_e    state_q, state_d;
    logic [DBNC_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              s;
    logic              pwr_ok;

    gf180mcu_fd_sc_mcu9t5v0__evtsync_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (CLK),
        .rn  (RN),
        .d   (EVT),
        .q   (s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        evt_cnt_d = evt_cnt_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = FILT;
                    cnt_d   = DBNC_W'(1);
                end
            end
            FILT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DBNC_W'(DBNC_CYC)) begin
                    state_d = ASSERT;
                end else begin
                    cnt_d = cnt_q + DBNC_W'(1);
                end
            end
            ASSERT: begin
                if (ACK) begin
                    state_d   = REARM;
                    evt_cnt_d = CNT_W'(sat_inc(32'(evt_cnt_q), CNT_W));
                end
            end
            REARM: begin
                // A level still held high must drop before a new event can start.
                if (!s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d  = (state_d == ASSERT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            evt_cnt_q <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            evt_cnt_q <= evt_cnt_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
        end
    end

    assign pwr_ok  = (VDD === 1'b1) && (VSS === 1'b0);
    assign REQ     = pwr_ok ? req_q : 1'bx;
    assign BUSY    = pwr_ok ? busy_q : 1'bx;
    assign EVT_CNT = pwr_ok ? evt_cnt_q : {CNT_W{1'bx}};

`ifdef GF180MCU_EVTSYNC_TIMING_EN
    specify
        (posedge CLK => REQ) = (1.0, 1.0);
        (posedge CLK => BUSY) = (1.0, 1.0);
        (posedge CLK => EVT_CNT) = (1.0, 1.0);
        $setuphold(posedge CLK, ACK, 0.1, 0.1);
        $setuphold(posedge CLK, RN, 0.1, 0.1);
        $width(posedge CLK, 0.5);
        $width(negedge CLK, 0.5);
    endspecify
`else
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__evtsync_1.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__evtsync_1.sv - directed self-checking bench for the event synchroniser
module tb_gf180mcu_fd_sc_mcu9t5v0__evtsync_1;

    logic       clk = 1'b0;
    logic       rn  = 1'b0;
    logic       evt = 1'b0;
    logic       ack = 1'b0;
    logic       req_a, busy_a;
    logic [7:0] cnt_a;
    logic       req_b, busy_b;
    logic [1:0] cnt_b;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__evtsync_1 dut_a (
        .CLK     (clk),
        .RN      (rn),
        .EVT     (evt),
        .ACK     (ack),
        .REQ     (req_a),
        .BUSY    (busy_a),
        .EVT_CNT (cnt_a),
        .VDD     (vdd),
        .VSS     (vss)
    );

    gf180mcu_fd_sc_mcu9t5v0__evtsync_1 #(.CNT_W(2)) dut_b (
        .CLK     (clk),
        .RN      (rn),
        .EVT     (evt),
        .ACK     (ack),
        .REQ     (req_b),
        .BUSY    (busy_b),
        .EVT_CNT (cnt_b),
        .VDD     (vdd),
        .VSS     (vss)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rn = 1'b0;
        tick();
        rn = 1'b1;
    endtask

    task automatic run_event();
        evt = 1'b1;
        repeat (11) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        evt = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        evt = 1'b0;
        ack = 1'b0;
        do_reset();
        checks++;
        if (req_a !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL reset: req=%b busy=%b cnt=%0d expected 0 0 0", req_a, busy_a, cnt_a);
        end
    endtask

    task automatic test_clean_event();
        do_reset();
        evt = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            checks++;
            if (req_a !== 1'b0) begin
                failures++;
                $display("FAIL clean_early edge=%0d: req=%b expected 0", e, req_a);
            end
        end
        tick();
        checks++;
        if (req_a !== 1'b1 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL clean_assert: req=%b busy=%b expected 1 1", req_a, busy_a);
        end
        repeat (3) tick();
        checks++;
        if (req_a !== 1'b1 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL clean_hold: req=%b cnt=%0d expected 1 0", req_a, cnt_a);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (req_a !== 1'b0 || cnt_a !== 8'd1 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL clean_ack: req=%b cnt=%0d busy=%b expected 0 1 1", req_a, cnt_a, busy_a);
        end
        evt = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL clean_idle: busy=%b expected 0", busy_a);
        end
    endtask

    task automatic test_glitch();
        logic seen_req;
        do_reset();
        seen_req = 1'b0;
        evt = 1'b1;
        for (int e = 0; e < 12; e++) begin
            if (e == 3) evt = 1'b0;
            tick();
            if (req_a) seen_req = 1'b1;
            if (e == 2) begin
                checks++;
                if (busy_a !== 1'b1) begin
                    failures++;
                    $display("FAIL glitch_filt: busy=%b expected 1", busy_a);
                end
            end
        end
        checks++;
        if (seen_req !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL glitch: seen_req=%b busy=%b cnt=%0d expected 0 0 0", seen_req, busy_a, cnt_a);
        end
    endtask

    task automatic test_held_level();
        logic seen_req;
        do_reset();
        evt = 1'b1;
        repeat (11) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        seen_req = 1'b0;
        repeat (20) begin
            tick();
            if (req_a || !busy_a) seen_req = 1'b1;
        end
        checks++;
        if (seen_req !== 1'b0 || cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL held_rearm: retrigger=%b cnt=%0d expected 0 1", seen_req, cnt_a);
        end
        evt = 1'b0;
        repeat (2) tick();
        evt = 1'b1;
        tick();
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL held_idle: busy=%b expected 0", busy_a);
        end
        repeat (9) tick();
        checks++;
        if (req_a !== 1'b0) begin
            failures++;
            $display("FAIL held_early: req=%b expected 0", req_a);
        end
        tick();
        checks++;
        if (req_a !== 1'b1) begin
            failures++;
            $display("FAIL held_second_req: req=%b expected 1", req_a);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        evt = 1'b0;
        repeat (3) tick();
        checks++;
        if (cnt_a !== 8'd2 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL held_count: cnt=%0d busy=%b expected 2 0", cnt_a, busy_a);
        end
    endtask

    task automatic test_spurious_ack();
        do_reset();
        ack = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy_a !== 1'b0 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL spurious_idle: busy=%b cnt=%0d expected 0 0", busy_a, cnt_a);
        end
        evt = 1'b1;
        repeat (6) tick();
        checks++;
        if (busy_a !== 1'b1 || req_a !== 1'b0 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL spurious_filt: busy=%b req=%b cnt=%0d expected 1 0 0", busy_a, req_a, cnt_a);
        end
        repeat (4) tick();
        ack = 1'b0;
        tick();
        checks++;
        if (req_a !== 1'b1 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL spurious_assert: req=%b cnt=%0d expected 1 0", req_a, cnt_a);
        end
    endtask

    task automatic test_reset_mid_op();
        rn = 1'b0;
        tick();
        rn = 1'b1;
        checks++;
        if (req_a !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL midreset: req=%b busy=%b cnt=%0d expected 0 0 0", req_a, busy_a, cnt_a);
        end
        repeat (10) tick();
        checks++;
        if (req_a !== 1'b0) begin
            failures++;
            $display("FAIL midreset_early: req=%b expected 0", req_a);
        end
        tick();
        checks++;
        if (req_a !== 1'b1) begin
            failures++;
            $display("FAIL midreset_new_req: req=%b expected 1", req_a);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        evt = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_b [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_event();
            checks++;
            if (cnt_b !== exp_b[i] || cnt_a !== 8'(i + 1)) begin
                failures++;
                $display("FAIL saturation event=%0d: cnt2=%0d cnt8=%0d expected %0d %0d",
                         i, cnt_b, cnt_a, exp_b[i], i + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_event();
        test_glitch();
        test_held_level();
        test_spurious_ack();
        test_reset_mid_op();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
